// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper
// Description : Drives a/b/c through 000..111, samples y once per combination,
//               and compares the captured truth table against an expected one.
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweeper #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] expected,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] truth_table,
    output logic [7:0] mismatch
);

    localparam int              CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]    r_state;
    logic [2:0]    r_idx;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_expected;
    logic [7:0]    w_next_table;
    logic          w_accept;

    // Table including the sample taken this edge, so the final bit is part of the compare.
    always_comb begin
        w_next_table        = truth_table;
        w_next_table[r_idx] = y;
    end

    // The DONE exit edge also accepts a new start, giving back-to-back sweeps every 8*DWELL+1 cycles.
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    assign busy = (r_state == S_DRIVE);
    assign done = (r_state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= 3'd0;
            r_cnt       <= '0;
            r_expected  <= 8'h00;
            {a, b, c}   <= 3'b000;
            pass        <= 1'b0;
            truth_table <= 8'h00;
            mismatch    <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    {a, b, c} <= 3'b000;
                    if (w_accept) begin
                        r_expected  <= expected;
                        truth_table <= 8'h00;
                        mismatch    <= 8'h00;
                        pass        <= 1'b0;
                        r_idx       <= 3'd0;
                        r_cnt       <= '0;
                        r_state     <= S_DRIVE;
                    end else begin
                        r_state     <= S_IDLE;
                    end
                end
                S_DRIVE: begin
                    if (r_cnt != CNT_LAST) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        truth_table <= w_next_table;
                        if (r_idx == 3'd7) begin
                            pass     <= (w_next_table == r_expected);
                            mismatch <= w_next_table ^ r_expected;
                            r_state  <= S_DONE;
                        end else begin
                            r_idx     <= r_idx + 3'd1;
                            {a, b, c} <= r_idx + 3'd1;
                            r_cnt     <= '0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// Bench for truth_table_sweeper: three instances (DWELL 4, 2, 1) each wired to a
// reference boolean function; results go through a scoreboard queue.
module tb_truth_table_sweeper;

    typedef struct packed {
        logic [7:0] tbl;
        logic       pass;
        logic [7:0] mis;
    } res_t;

    res_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       start4 = 1'b0, start2 = 1'b0, start1 = 1'b0;
    logic [7:0] expected4 = 8'h00, expected2 = 8'h00, expected1 = 8'h00;
    logic       a4, b4, c4, busy4, done4, pass4, y4;
    logic       a2, b2, c2, busy2, done2, pass2, y2;
    logic       a1, b1, c1, busy1, done1, pass1, y1;
    logic [7:0] tt4, mis4, tt2, mis2, tt1, mis1;

    assign y4 = (a4 & b4) | (a4 & c4) | (b4 & c4);
    assign y2 = (a2 & b2) | (a2 & c2) | (b2 & c2);
    assign y1 = a1 ^ b1 ^ c1;

    truth_table_sweeper #(.DWELL(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .expected(expected4), .y(y4),
        .a(a4), .b(b4), .c(c4), .busy(busy4), .done(done4), .pass(pass4),
        .truth_table(tt4), .mismatch(mis4));
    truth_table_sweeper #(.DWELL(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .expected(expected2), .y(y2),
        .a(a2), .b(b2), .c(c2), .busy(busy2), .done(done2), .pass(pass2),
        .truth_table(tt2), .mismatch(mis2));
    truth_table_sweeper #(.DWELL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .expected(expected1), .y(y1),
        .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
        .truth_table(tt1), .mismatch(mis1));

    function automatic logic [7:0] model_tt(input bit is_xor);
        logic [7:0] t;
        t = 8'h00;
        for (int k = 0; k < 8; k++) begin
            logic [2:0] kk;
            kk = 3'(k);
            t[k] = is_xor ? (kk[2] ^ kk[1] ^ kk[0])
                          : ((kk[2] & kk[1]) | (kk[2] & kk[0]) | (kk[1] & kk[0]));
        end
        return t;
    endfunction

    function automatic res_t model_res(input bit is_xor, input logic [7:0] exp_tt);
        res_t r;
        r.tbl  = model_tt(is_xor);
        r.pass = (r.tbl == exp_tt);
        r.mis  = r.tbl ^ exp_tt;
        return r;
    endfunction

    task automatic test_reset;
        #12 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({a4, b4, c4, busy4, done4, pass4, tt4, mis4} !== 22'h0) begin
            n_fail++;
            $display("FAIL reset_async: got abc=%b busy=%b done=%b pass=%b table=%h mis=%h required all 0",
                     {a4, b4, c4}, busy4, done4, pass4, tt4, mis4);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({a1, b1, c1, busy1, done1, pass1, tt1, mis1, a4, b4, c4, busy4, done4, pass4, tt4, mis4} !== 44'h0) begin
            n_fail++;
            $display("FAIL reset_release: outputs not quiescent after release (dut1 table=%h dut4 table=%h) required 0",
                     tt1, tt4);
        end
    endtask

    task automatic test_majority_pass;
        res_t r;
        expected4 = 8'hE8;
        start4    = 1'b1;
        sb.push_back(model_res(1'b0, 8'hE8));
        @(negedge clk);
        start4 = 1'b0;
        for (int t = 0; t < 32; t++) begin
            n_vec++;
            if ({a4, b4, c4} !== 3'(t / 4) || busy4 !== 1'b1 || done4 !== 1'b0) begin
                n_fail++;
                $display("FAIL maj_step t=%0d: got abc=%b busy=%b done=%b required abc=%b busy=1 done=0",
                         t, {a4, b4, c4}, busy4, done4, 3'(t / 4));
            end
            @(negedge clk);
        end
        r = sb.pop_front();
        n_vec++;
        if (done4 !== 1'b1 || busy4 !== 1'b0 || tt4 !== r.tbl || pass4 !== r.pass || mis4 !== r.mis) begin
            n_fail++;
            $display("FAIL maj_pass_result: got done=%b busy=%b table=%h pass=%b mis=%h required done=1 busy=0 table=%h pass=%b mis=%h",
                     done4, busy4, tt4, pass4, mis4, r.tbl, r.pass, r.mis);
        end
        @(negedge clk);
        n_vec++;
        if (done4 !== 1'b0 || {a4, b4, c4} !== 3'b000 || pass4 !== 1'b1) begin
            n_fail++;
            $display("FAIL maj_after_done: got done=%b abc=%b pass=%b required done=0 abc=000 pass=1",
                     done4, {a4, b4, c4}, pass4);
        end
    endtask

    task automatic test_majority_fail;
        res_t r;
        int   cnt;
        expected4 = 8'hE9;
        start4    = 1'b1;
        sb.push_back(model_res(1'b0, 8'hE9));
        @(negedge clk);
        start4 = 1'b0;
        cnt = 0;
        while (done4 !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        n_vec++;
        if (cnt != 32) begin
            n_fail++;
            $display("FAIL maj_fail_latency: got %0d cycles required 32", cnt);
        end
        r = sb.pop_front();
        n_vec++;
        if (tt4 !== r.tbl || pass4 !== r.pass || mis4 !== r.mis) begin
            n_fail++;
            $display("FAIL maj_fail_result: got table=%h pass=%b mis=%h required table=%h pass=%b mis=%h",
                     tt4, pass4, mis4, r.tbl, r.pass, r.mis);
        end
        expected4 = 8'h00;
        repeat (5) @(negedge clk);
        n_vec++;
        if (pass4 !== r.pass || mis4 !== r.mis || tt4 !== r.tbl) begin
            n_fail++;
            $display("FAIL maj_fail_hold: got table=%h pass=%b mis=%h required table=%h pass=%b mis=%h",
                     tt4, pass4, mis4, r.tbl, r.pass, r.mis);
        end
    endtask

    task automatic test_start_during_sweep;
        res_t r;
        int   n_done;
        expected2 = 8'hE8;
        start2    = 1'b1;
        repeat (3) sb.push_back(model_res(1'b0, 8'hE8));
        n_done = 0;
        for (int t = 1; t <= 51; t++) begin
            @(negedge clk);
            if (t % 17 == 5)  expected2 = 8'h00;
            if (t % 17 == 12) expected2 = 8'hE8;
            n_vec++;
            if (done2 !== (t % 17 == 0)) begin
                n_fail++;
                $display("FAIL held_start_done t=%0d: got done=%b required %b", t, done2, (t % 17 == 0));
            end
            if (done2 === 1'b1) begin
                n_done++;
                r = sb.pop_front();
                n_vec++;
                if (tt2 !== r.tbl || pass2 !== r.pass || mis2 !== r.mis) begin
                    n_fail++;
                    $display("FAIL held_start_result t=%0d: got table=%h pass=%b mis=%h required table=%h pass=%b mis=%h",
                             t, tt2, pass2, mis2, r.tbl, r.pass, r.mis);
                end
            end
        end
        start2 = 1'b0;
        n_vec++;
        if (n_done != 3) begin
            n_fail++;
            $display("FAIL held_start_count: got %0d done pulses required 3", n_done);
        end
        sb.delete();
    endtask

    task automatic test_min_dwell;
        res_t r;
        expected1 = 8'h96;
        start1    = 1'b1;
        sb.push_back(model_res(1'b1, 8'h96));
        @(negedge clk);
        start1 = 1'b0;
        for (int t = 0; t < 8; t++) begin
            n_vec++;
            if ({a1, b1, c1} !== 3'(t) || done1 !== 1'b0) begin
                n_fail++;
                $display("FAIL dwell1_step t=%0d: got abc=%b done=%b required abc=%b done=0",
                         t, {a1, b1, c1}, done1, 3'(t));
            end
            @(negedge clk);
        end
        r = sb.pop_front();
        n_vec++;
        if (done1 !== 1'b1 || tt1 !== r.tbl || pass1 !== r.pass || mis1 !== r.mis) begin
            n_fail++;
            $display("FAIL dwell1_result: got done=%b table=%h pass=%b mis=%h required done=1 table=%h pass=%b mis=%h",
                     done1, tt1, pass1, mis1, r.tbl, r.pass, r.mis);
        end
    endtask

    task automatic test_reset_mid_sweep;
        int n_done;
        expected4 = 8'hE8;
        start4    = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (14) @(negedge clk);
        n_vec++;
        if ({a4, b4, c4} !== 3'd3 || busy4 !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre: got abc=%b busy=%b required abc=011 busy=1", {a4, b4, c4}, busy4);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({a4, b4, c4} !== 3'b000 || tt4 !== 8'h00 || busy4 !== 1'b0 || done4 !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_async: got abc=%b table=%h busy=%b done=%b required 000 00 0 0",
                     {a4, b4, c4}, tt4, busy4, done4);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (done4 === 1'b1 || busy4 === 1'b1) n_done++;
        end
        n_vec++;
        if (n_done != 0 || {a4, b4, c4} !== 3'b000) begin
            n_fail++;
            $display("FAIL midreset_no_done: got %0d busy/done cycles abc=%b required 0 and 000",
                     n_done, {a4, b4, c4});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_majority_pass();
        test_majority_fail();
        test_start_during_sweep();
        test_min_dwell();
        test_reset_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
